lsu_mem_stage: RTL

- Load/store stage directly downstream of the decoder and register file in the RV32I core.
- Consumes MemRead/MemWrite, funct3, the effective address and busB store data. Produces sign/zero-extended load data for the writeback mux that feeds busW.
- Drives a single-outstanding req/ack data-memory bus.
- Asserts stall to freeze the PC while an access is in flight.

---
 rtl/lsu_mem_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I load/store stage: single-outstanding req/ack data bus, load extension, PC stall.
// Optional LSU_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES unacknowledged REQ cycles.
module lsu_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_cause_q, fault_cause_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    logic        access, misaligned, illegal;
    logic [3:0]  strb_base;
    logic [31:0] wdata_lanes, rdata_shifted, load_ext;
    logic [15:0] rdata_half;

    always_comb begin
        access     = mem_read | mem_write;
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        illegal    = (mem_read && mem_write) ||
                     (mem_write && (funct3[2] || (&funct3[1:0]))) ||
                     (mem_read && ((&funct3[1:0]) || (funct3[2] && funct3[1])));

        case (funct3[1:0])
            2'b00:   begin strb_base = 4'b0001; wdata_lanes = {4{store_data[7:0]}};  end
            2'b01:   begin strb_base = 4'b0011; wdata_lanes = {2{store_data[15:0]}}; end
            default: begin strb_base = 4'b1111; wdata_lanes = store_data;            end
        endcase

        // Extraction uses the funct3/offset latched at request time, not the live inputs.
        rdata_shifted = bus_rdata >> {addr_lo_q, 3'b000};
        rdata_half    = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
            3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'd0, rdata_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wstrb_d   = bus_wstrb_q;
        load_data_d   = load_data_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // Illegal takes priority over misaligned when both apply.
                    if (illegal) begin
                        state_d       = ST_DONE;
                        fault_d       = 1'b1;
                        fault_cause_d = 2'b01;
                    end else if (misaligned) begin
                        state_d       = ST_DONE;
                        fault_d       = 1'b1;
                        fault_cause_d = 2'b00;
                    end else begin
                        state_d     = ST_REQ;
                        fault_d     = 1'b0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = mem_write ? wdata_lanes : 32'd0;
                        bus_wstrb_d = mem_write ? (strb_base << addr[1:0]) : 4'b0000;
                        funct3_d    = funct3;
                        addr_lo_d   = addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d = load_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_DONE;
                    bus_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_wstrb_q   <= '0;
            load_data_q   <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            funct3_q      <= 3'b000;
            addr_lo_q     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
            load_data_q   <= load_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign done        = (state_q == ST_DONE);
    assign fault       = done & fault_q;
    assign fault_cause = done ? fault_cause_q : 2'b00;
    assign stall       = ((state_q == ST_IDLE) && (mem_read || mem_write)) || (state_q == ST_REQ);
    assign load_data   = load_data_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_wstrb   = bus_wstrb_q;

endmodule
